// File: rtl/alu_logic_pkg.sv
// Shared op-code and FSM state types for the multi-cycle bitwise logic unit.
package alu_logic_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_EOR  = 3'b001,
        OP_ORR  = 3'b010,
        OP_BIC  = 3'b011,
        OP_MVN  = 3'b100,
        OP_MOV  = 3'b101,
        OP_XNOR = 3'b110,
        OP_NAND = 3'b111
    } alu_logic_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_logic_state_e;

endpackage

// File: rtl/alu_logic_lane.sv
// Combinational W-bit slice of the logic unit; the top reuses one instance for every lane.
module alu_logic_lane
    import alu_logic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  alu_logic_op_e op,
    output logic [W-1:0]  y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_EOR:  y = a ^ b;
            OP_ORR:  y = a | b;
            OP_BIC:  y = a & ~b;
            OP_MVN:  y = ~b;
            OP_MOV:  y = b;
            OP_XNOR: y = ~(a ^ b);
            OP_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_logic_unit.sv
// Multi-cycle bitwise logic unit: LANE_W bits per cycle, N/Z flags, valid/ready on both sides.
// Optional parity flag output flag_p is enabled by defining ALU_LOGIC_PARITY_EN.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready=1
// RUN     | one lane of the result written per cycle from latched operands
// DONE    | result/flags held with out_valid=1 until consumer accepts
module alu_logic_unit
    import alu_logic_pkg::*;
#(
    parameter int N      = 32,
    parameter int LANE_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         flag_n,
    output logic         flag_z
`ifdef ALU_LOGIC_PARITY_EN
    ,
    output logic         flag_p
`endif
);

    localparam int L   = N / LANE_W;
    localparam int LCW = (L > 1) ? $clog2(L) : 1;

    generate
        if (LANE_W < 1 || (N % LANE_W) != 0) begin : g_bad_lane_w
            $error("alu_logic_unit: LANE_W must divide N");
        end
    endgenerate

    alu_logic_state_e state_q, state_d;
    logic [LCW-1:0]   lane_q;
    logic [N-1:0]     a_q, b_q, result_q, result_nxt;
    alu_logic_op_e    op_q;
    logic [LANE_W-1:0] a_lane, b_lane, y_lane;
    logic             flag_n_q, flag_z_q, flag_p_q;
    logic             accept, deliver, last_lane;

    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign last_lane = (lane_q == LCW'(L - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last_lane) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Constant-index lane mux keeps the part-selects static.
    always_comb begin
        a_lane = '0;
        b_lane = '0;
        for (int i = 0; i < L; i++) begin
            if (lane_q == LCW'(i)) begin
                a_lane = a_q[i*LANE_W +: LANE_W];
                b_lane = b_q[i*LANE_W +: LANE_W];
            end
        end
    end

    alu_logic_lane #(.W(LANE_W)) u_lane (
        .a  (a_lane),
        .b  (b_lane),
        .op (op_q),
        .y  (y_lane)
    );

    always_comb begin
        result_nxt = result_q;
        for (int i = 0; i < L; i++) begin
            if (lane_q == LCW'(i)) result_nxt[i*LANE_W +: LANE_W] = y_lane;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            lane_q   <= '0;
            result_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_p_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= in1;
                b_q      <= in2;
                op_q     <= alu_logic_op_e'(op);
                lane_q   <= '0;
                result_q <= '0;
            end else if (state_q == ST_RUN) begin
                result_q <= result_nxt;
                lane_q   <= last_lane ? '0 : lane_q + LCW'(1);
                if (last_lane) begin
                    flag_n_q <= result_nxt[N-1];
                    flag_z_q <= (result_nxt == '0);
                    flag_p_q <= ^result_nxt;
                end
            end
            // Flags only ever read non-zero while DONE holds the result.
            if (deliver) begin
                flag_n_q <= 1'b0;
                flag_z_q <= 1'b0;
                flag_p_q <= 1'b0;
            end
        end
    end

    assign result = result_q;
    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;
`ifdef ALU_LOGIC_PARITY_EN
    assign flag_p = flag_p_q;
`else
    logic unused_p;
    assign unused_p = flag_p_q;
`endif

endmodule

// File: tb/tb_alu_logic_unit.sv
// Scoreboard bench for alu_logic_unit: DUT a uses LANE_W=8, DUT b uses LANE_W=32.
module tb_alu_logic_unit;
    import alu_logic_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flag_n, a_flag_z;
    logic [2:0]  a_op;
    logic [31:0] a_in1, a_in2, a_result;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flag_n, b_flag_z;
    logic [2:0]  b_op;
    logic [31:0] b_in1, b_in2, b_result;
`ifdef ALU_LOGIC_PARITY_EN
    logic        a_flag_p, b_flag_p;
`endif

    alu_logic_unit #(.N(32), .LANE_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .op(a_op),
        .in1(a_in1), .in2(a_in2), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .result(a_result), .flag_n(a_flag_n), .flag_z(a_flag_z)
`ifdef ALU_LOGIC_PARITY_EN
        , .flag_p(a_flag_p)
`endif
    );

    alu_logic_unit #(.N(32), .LANE_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .op(b_op),
        .in1(b_in1), .in2(b_in2), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .result(b_result), .flag_n(b_flag_n), .flag_z(b_flag_z)
`ifdef ALU_LOGIC_PARITY_EN
        , .flag_p(b_flag_p)
`endif
    );

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t cur_a, cur_b;
    logic prev_a = 1'b0, prev_b = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitors: pop on the rising edge of out_valid, then hold-check every DONE cycle.
    always @(negedge clk) begin
        if (a_out_valid) begin
            if (!prev_a) begin
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_output: got %h expected none", a_result);
                end else begin
                    cur_a = q_a.pop_front();
                    chk("a_latency", cyc, cur_a.due);
                end
            end
            chk("a_result", a_result, cur_a.res);
            chk("a_flag_n", 32'(a_flag_n), 32'(cur_a.res[31]));
            chk("a_flag_z", 32'(a_flag_z), 32'(cur_a.res == 32'h0));
`ifdef ALU_LOGIC_PARITY_EN
            chk("a_flag_p", 32'(a_flag_p), 32'(^cur_a.res));
`endif
        end else begin
            chk("a_flags_outside_done", {30'h0, a_flag_n, a_flag_z}, 32'h0);
        end
        prev_a = a_out_valid;
    end

    always @(negedge clk) begin
        if (b_out_valid) begin
            if (!prev_b) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_output: got %h expected none", b_result);
                end else begin
                    cur_b = q_b.pop_front();
                    chk("b_latency", cyc, cur_b.due);
                end
            end
            chk("b_result", b_result, cur_b.res);
            chk("b_flag_n", 32'(b_flag_n), 32'(cur_b.res[31]));
            chk("b_flag_z", 32'(b_flag_z), 32'(cur_b.res == 32'h0));
`ifdef ALU_LOGIC_PARITY_EN
            chk("b_flag_p", 32'(b_flag_p), 32'(^cur_b.res));
`endif
        end else begin
            chk("b_flags_outside_done", {30'h0, b_flag_n, b_flag_z}, 32'h0);
        end
        prev_b = b_out_valid;
    end

    // Called just after a negedge; returns just after the following negedge.
    task automatic send(input int w, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_res);
        int n = 0;
        exp_t e;
        if (w == 0) begin a_op = o; a_in1 = x; a_in2 = y; a_in_valid = 1'b1; end
        else        begin b_op = o; b_in1 = x; b_in2 = y; b_in_valid = 1'b1; end
        #1;
        while (!(w == 0 ? a_in_ready : b_in_ready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles (dut %0d)", w);
        end else begin
            e.res = exp_res;
            e.due = cyc + 1 + ((w == 0) ? 4 : 1);
            if (w == 0) q_a.push_back(e); else q_b.push_back(e);
        end
        @(posedge clk); #1;
        if (w == 0) begin a_in_valid = 1'b0; a_in1 = $urandom; a_in2 = $urandom; a_op = 3'($urandom); end
        else        begin b_in_valid = 1'b0; b_in1 = $urandom; b_in2 = $urandom; b_op = 3'($urandom); end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || a_out_valid || b_out_valid) && n < 60) begin
            @(negedge clk); n++;
        end
        if (n >= 60) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q_a.size(), q_b.size());
        end
    endtask

    initial begin
        int n;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_op = 3'd0; a_in1 = '0; a_in2 = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_op = 3'd0; b_in1 = '0; b_in2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_a_out_valid", 32'(a_out_valid), 32'h0);
        chk("rst_a_in_ready",  32'(a_in_ready),  32'h1);
        chk("rst_a_result",    a_result,         32'h0);
        chk("rst_b_in_ready",  32'(b_in_ready),  32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        send(0, OP_EOR, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
        drain();
        send(0, OP_EOR, 32'h0000_0002, 32'h0000_0002, 32'h0000_0000);
        send(0, OP_EOR, 32'h0000_000F, 32'h0000_0005, 32'h0000_000A);
        send(0, OP_EOR, 32'h5555_5555, 32'hF222_222F, 32'hA777_777A);
        send(0, OP_BIC, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000);
        send(0, OP_XNOR, 32'hFFFF_0000, 32'hFF00_FF00, 32'hFF00_00FF);
        send(0, OP_NAND, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
        send(0, OP_MOV, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000);
        send(0, OP_ORR, 32'h00FF_0000, 32'h0000_00FF, 32'h00FF_00FF);
        drain();

        // Backpressure, then handoff accept in the same cycle the result leaves.
        a_out_ready = 1'b0;
        send(0, OP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000);
        n = 0;
        while (!a_out_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_reached_done", 32'(a_out_valid), 32'h1);
        repeat (3) begin
            #1 chk("bp_in_ready", 32'(a_in_ready), 32'h0);
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        #1 chk("handoff_in_ready", 32'(a_in_ready), 32'h1);
        send(0, OP_MVN, 32'h0, 32'hFFFF_FFFF, 32'h0000_0000);
        drain();

        // Reset two cycles into RUN.
        send(0, OP_ORR, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 32'(a_out_valid), 32'h0);
        chk("midrun_rst_result",    a_result,         32'h0);
        chk("midrun_rst_flags",     {30'h0, a_flag_n, a_flag_z}, 32'h0);
        chk("midrun_rst_in_ready",  32'(a_in_ready),  32'h1);
        q_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, OP_ORR, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
        drain();

        // Single-lane instance: one-cycle latency.
        send(1, OP_BIC, 32'h0000_000F, 32'h0000_0005, 32'h0000_000A);
        send(1, OP_ORR, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003);
        send(1, OP_AND, 32'h0000_0007, 32'h0000_0007, 32'h0000_0007);
        send(1, OP_NAND, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
        send(1, OP_EOR, 32'h8000_0001, 32'h0000_0001, 32'h8000_0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
